// File: rtl/flag_register_stack.sv
// Status-flag register with a small LIFO for saving/restoring flags across CALL/RET and interrupts.
// Flags update from ALU (masked), an explicit load, or a stack pop; stack overflow/underflow are sticky.
module flag_register_stack #(
    parameter int DEPTH = 4,
    parameter int SP_W  = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [4:0]      alu_flag_i,
    input  logic [4:0]      wr_mask_i,
    input  logic            load_f_i,
    input  logic [4:0]      din_i,
    input  logic            push_i,
    input  logic            pop_i,
    output logic [4:0]      r_flag_o,
    output logic [SP_W-1:0] sp_cnt_o,
    output logic            stk_empty_o,
    output logic            stk_full_o,
    output logic            stk_ovf_o,
    output logic            stk_unf_o
);

    logic [4:0]            flag_q, flag_d;
    logic [SP_W-1:0]       sp_q, sp_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [DEPTH-1:0][4:0] stk_q;
    logic [4:0]            top;
    logic                  empty, full, push_ok, pop_ok;

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SP_W'(DEPTH));
    // A simultaneous push+pop never moves the pointer; only the pop side reads.
    assign push_ok = push_i && !pop_i && !full;
    assign pop_ok  = pop_i && !empty;

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) top = stk_q[i];
        end

        flag_d = (flag_q & ~wr_mask_i) | (alu_flag_i & wr_mask_i);
        if (pop_ok)        flag_d = top;
        else if (load_f_i) flag_d = din_i;

        sp_d = sp_q;
        if (push_ok)               sp_d = sp_q + 1'b1;
        else if (pop_ok && !push_i) sp_d = sp_q - 1'b1;

        ovf_d = ovf_q | (push_i & full);
        unf_d = unf_q | (pop_i & empty);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flag_q <= '0;
            sp_q   <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            sp_q   <= sp_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Stack storage needs no reset: entries above the pointer are never read.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst_i && push_ok && sp_q == SP_W'(i)) stk_q[i] <= flag_q;
        end
    end

    assign r_flag_o    = flag_q;
    assign sp_cnt_o    = sp_q;
    assign stk_empty_o = empty;
    assign stk_full_o  = full;
    assign stk_ovf_o   = ovf_q;
    assign stk_unf_o   = unf_q;

endmodule
